// File: rtl/jtdd_objbuf_if.sv
// jtdd_objbuf_if: bundles the object line buffer's pixel-side and draw-side
// signals. The master drives timing/draw inputs; the slave (the buffer)
// returns the object pixel and the clear-sweep status.
interface jtdd_objbuf_if #(
  parameter int AW = 9,
  parameter int DW = 8
);
  logic          pxl_cen;
  logic          HBL;
  logic [AW-1:0] hdump;
  logic          flip;
  logic          wr_en;
  logic [AW-1:0] wr_x;
  logic [DW-1:0] wr_pxl;
  logic [DW-1:0] obj_pxl;
  logic          busy;

  modport master (
    output pxl_cen, HBL, hdump, flip, wr_en, wr_x, wr_pxl,
    input  obj_pxl, busy
  );

  modport slave (
    input  pxl_cen, HBL, hdump, flip, wr_en, wr_x, wr_pxl,
    output obj_pxl, busy
  );
endinterface

// File: rtl/jtdd_objbuf.sv
// jtdd_objbuf: double-banked object line buffer feeding the colour mixer.
// One bank is scanned out at pixel rate (erase-after-read) while the object
// renderer draws the next line into the other bank; banks swap on every
// rising edge of HBL. A sweep after reset zeroes both banks.
// Build option: define JTDD_OBJBUF_FIRSTWIN_EN for first-opaque-pixel-wins
// drawing (two-stage read-modify-write); otherwise the last opaque write wins.
module jtdd_objbuf #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic        clk,
  input  logic        rst,
  jtdd_objbuf_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t        state_q;
  logic [AW-1:0] clr_addr_q;
  logic          busy_q;
  logic [DW-1:0] obj_pxl_q;
  logic          rdbank_q;
  logic          hbl_l_q;

  // Pending erase of the location read on the previous pixel
  logic          er_valid_q;
  logic [AW-1:0] er_addr_q;
  logic          er_bank_q;

  // NOTE: line memories carry no reset; the clear sweep zeroes them instead,
  // which keeps them mappable onto block RAM.
  logic [DW-1:0] mem_q [2][DEPTH];

  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          opaque;

  // Draw-side write request into the bank write mux
  logic          draw_we;
  logic [AW-1:0] draw_addr;
  logic [DW-1:0] draw_data;
  logic          draw_bank;

  // Per-bank write port
  logic          bank_we   [2];
  logic [AW-1:0] bank_addr [2];
  logic [DW-1:0] bank_data [2];

  assign opaque      = (bus.wr_pxl[3:0] != 4'd0);
  assign bus.obj_pxl = obj_pxl_q;
  assign bus.busy    = busy_q;

  // Display-side read address and data; a same-address erase still in flight
  // is forwarded so a back-to-back read sees the erased value.
  always_comb begin
    rd_addr = bus.flip ? ~bus.hdump : bus.hdump;
    if (er_valid_q && (er_bank_q == rdbank_q) && (er_addr_q == rd_addr)) begin
      rd_data = '0;
    end else begin
      rd_data = mem_q[rdbank_q][rd_addr];
    end
  end

`ifdef JTDD_OBJBUF_FIRSTWIN_EN
  logic          s1_valid_q;
  logic [AW-1:0] s1_x_q;
  logic [DW-1:0] s1_pxl_q;
  logic          s1_bank_q;
  logic [DW-1:0] s1_old_q;
  logic [DW-1:0] s1_old_d;

  // Stage-1 read of the draw bank, forwarding the stage-2 write in progress
  always_comb begin
    if (draw_we && (draw_bank == ~rdbank_q) && (draw_addr == bus.wr_x)) begin
      s1_old_d = draw_data;
    end else begin
      s1_old_d = mem_q[~rdbank_q][bus.wr_x];
    end
  end

  // Stage-1 capture: opaque requests only, latching the pre-swap draw bank
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_pxl_q   <= '0;
      s1_bank_q  <= 1'b0;
      s1_old_q   <= '0;
    end else begin
      s1_valid_q <= (state_q == ST_RUN) && bus.wr_en && opaque;
      s1_x_q     <= bus.wr_x;
      s1_pxl_q   <= bus.wr_pxl;
      s1_bank_q  <= ~rdbank_q;
      s1_old_q   <= s1_old_d;
    end
  end

  // Stage 2 writes only over a transparent stored pixel
  always_comb begin
    draw_we   = s1_valid_q && (s1_old_q[3:0] == 4'd0);
    draw_addr = s1_x_q;
    draw_data = s1_pxl_q;
    draw_bank = s1_bank_q;
  end
`else
  // Direct write of opaque pixels into the current draw bank
  always_comb begin
    draw_we   = (state_q == ST_RUN) && bus.wr_en && opaque;
    draw_addr = bus.wr_x;
    draw_data = bus.wr_pxl;
    draw_bank = ~rdbank_q;
  end
`endif

  // Bank write mux: sweep writes both banks, otherwise draw and erase
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    for (int b = 0; b < 2; b++) begin
      bank_we[b]   = 1'b0;
      bank_addr[b] = '0;
      bank_data[b] = '0;
    end
    if (state_q == ST_CLEAR) begin
      for (int b = 0; b < 2; b++) begin
        bank_we[b]   = 1'b1;
        bank_addr[b] = clr_addr_q;
      end
    end else begin
      if (draw_we) begin
        bank_we[draw_bank]   = 1'b1;
        bank_addr[draw_bank] = draw_addr;
        bank_data[draw_bank] = draw_data;
      end
      if (er_valid_q) begin
        bank_we[er_bank_q]   = 1'b1;
        bank_addr[er_bank_q] = er_addr_q;
        bank_data[er_bank_q] = '0;
      end
    end
  end

  // Line memory write ports
  always_ff @(posedge clk) begin
    for (int b = 0; b < 2; b++) begin
      if (bank_we[b]) begin
        mem_q[b][bank_addr[b]] <= bank_data[b];
      end
    end
  end

  // Control FSM: clear sweep, bank swap, pixel read and erase scheduling
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
      obj_pxl_q  <= '0;
      rdbank_q   <= 1'b0;
      hbl_l_q    <= 1'b0;
      er_valid_q <= 1'b0;
      er_addr_q  <= '0;
      er_bank_q  <= 1'b0;
    end else begin
      hbl_l_q <= bus.HBL;
      case (state_q)
        ST_CLEAR: begin
          busy_q     <= 1'b1;
          obj_pxl_q  <= '0;
          er_valid_q <= 1'b0;
          clr_addr_q <= clr_addr_q + AW'(1);
          if (clr_addr_q == '1) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy_q     <= 1'b0;
          er_valid_q <= 1'b0;
          if (bus.HBL && !hbl_l_q) begin
            rdbank_q <= ~rdbank_q;
          end
          if (bus.pxl_cen) begin
            if (bus.HBL) begin
              obj_pxl_q <= '0;
            end else begin
              obj_pxl_q  <= rd_data;
              er_valid_q <= 1'b1;
              er_addr_q  <= rd_addr;
              er_bank_q  <= rdbank_q;
            end
          end
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_jtdd_objbuf.sv
// tb_jtdd_objbuf: directed self-checking bench for jtdd_objbuf. Expected
// pixels are queued when a read is issued and popped when obj_pxl is sampled.
module tb_jtdd_objbuf;

  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [DW-1:0] exp_q [$];

  jtdd_objbuf_if #(.AW(AW), .DW(DW)) bus ();

  jtdd_objbuf #(.AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic f, input logic [DW-1:0] e, input string tag);
    bus.hdump   = a;
    bus.flip    = f;
    bus.HBL     = 1'b0;
    bus.pxl_cen = 1'b1;
    exp_q.push_back(e);
    tick();
    bus.pxl_cen = 1'b0;
    check(tag, 16'(bus.obj_pxl), 16'(exp_q.pop_front()));
  endtask

  task automatic draw(input logic [AW-1:0] x, input logic [DW-1:0] p);
    bus.wr_en  = 1'b1;
    bus.wr_x   = x;
    bus.wr_pxl = p;
    tick();
    bus.wr_en  = 1'b0;
    tick();
  endtask

  task automatic swap();
    bus.HBL = 1'b1;
    tick();
    bus.HBL = 1'b0;
    tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    bus.pxl_cen = 1'b0;
    bus.HBL     = 1'b0;
    bus.hdump   = '0;
    bus.flip    = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_x    = '0;
    bus.wr_pxl  = '0;

    // Reset state and clear sweep length
    rst = 1'b1;
    tick();
    tick();
    check("reset_busy", 16'(bus.busy), 16'h1);
    check("reset_obj", 16'(bus.obj_pxl), 16'h0);
    rst = 1'b0;
    count_busy(n);
    check("clear_cycles", 16'(n), 16'd512);
    check("run_obj", 16'(bus.obj_pxl), 16'h0);

    // Both banks fully zero after the sweep
    for (int i = 0; i < (1 << AW); i++) rd(AW'(i), 1'b0, 8'h00, "sweep_bank_a");
    swap();
    for (int i = 0; i < (1 << AW); i++) rd(AW'(i), 1'b0, 8'h00, "sweep_bank_b");

    // Draw, swap, scan; HBL blanks output; next visit of the bank is erased
    draw(9'h020, 8'h85);
    swap();
    rd(9'h020, 1'b0, 8'h85, "draw_read");
    bus.HBL = 1'b1;
    bus.pxl_cen = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    bus.pxl_cen = 1'b0;
    check("hbl_blank", 16'(bus.obj_pxl), 16'(exp_q.pop_front()));
    bus.HBL = 1'b0;
    tick();
    swap();
    rd(9'h020, 1'b0, 8'h00, "erased_next_line");

    // Back-to-back reads of one column while its erase is pending
    draw(9'h100, 8'h21);
    swap();
    rd(9'h100, 1'b0, 8'h21, "b2b_first");
    rd(9'h100, 1'b0, 8'h00, "b2b_second");

    // Flip addressing
    draw(9'h1DF, 8'h13);
    swap();
    rd(9'h020, 1'b1, 8'h13, "flip_read");

    // Transparent pixel does not overwrite
    draw(9'h030, 8'h41);
    draw(9'h030, 8'h70);
    swap();
    rd(9'h030, 1'b0, 8'h41, "transparent_keep");

    // Top column
    draw(9'h1FF, 8'h0A);
    swap();
    rd(9'h1FF, 1'b0, 8'h0A, "top_column");

    // Write in the swap cycle lands in the pre-swap draw bank
    bus.HBL    = 1'b1;
    bus.wr_en  = 1'b1;
    bus.wr_x   = 9'h060;
    bus.wr_pxl = 8'h55;
    tick();
    bus.HBL   = 1'b0;
    bus.wr_en = 1'b0;
    tick();
    tick();
    rd(9'h060, 1'b0, 8'h55, "swap_cycle_write");

    // Consecutive writes to one column
    bus.wr_en  = 1'b1;
    bus.wr_x   = 9'h050;
    bus.wr_pxl = 8'h12;
    tick();
    bus.wr_pxl = 8'h34;
    tick();
    bus.wr_en = 1'b0;
    tick();
    tick();
    swap();
`ifdef JTDD_OBJBUF_FIRSTWIN_EN
    rd(9'h050, 1'b0, 8'h12, "first_win");
`else
    rd(9'h050, 1'b0, 8'h34, "last_win");
`endif

    // Reset mid-line with a draw active
    draw(9'h070, 8'h66);
    bus.wr_en   = 1'b1;
    bus.wr_x    = 9'h070;
    bus.wr_pxl  = 8'h77;
    bus.pxl_cen = 1'b1;
    bus.hdump   = 9'h050;
    rst = 1'b1;
    tick();
    check("midrst_busy", 16'(bus.busy), 16'h1);
    check("midrst_obj", 16'(bus.obj_pxl), 16'h0);
    rst = 1'b0;
    bus.pxl_cen = 1'b0;
    count_busy(n);
    bus.wr_en = 1'b0;
    check("midrst_cycles", 16'(n), 16'd512);
    check("midrst_obj_after", 16'(bus.obj_pxl), 16'h0);
    rd(9'h070, 1'b0, 8'h00, "midrst_bank_a");
    rd(9'h000, 1'b0, 8'h00, "midrst_addr0_a");
    swap();
    rd(9'h070, 1'b0, 8'h00, "midrst_bank_b");
    rd(9'h000, 1'b0, 8'h00, "midrst_addr0_b");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
